// File: rtl/cnn_core_pkg.sv
// Shared definitions for the time-multiplexed CNN core: default geometry,
// derived arithmetic widths, FSM encoding and the output saturation helper.
// Used by cnn_core_seq (optional ReLU via CNN_CORE_RELU_EN lives there).
package cnn_core_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Default geometry; the saturation helper is sized from these.
    localparam int CNN_CI     = 4;
    localparam int CNN_KX     = 3;
    localparam int CNN_KY     = 3;
    localparam int CNN_I_F_BW = 8;
    localparam int CNN_W_BW   = 8;
    localparam int CNN_O_F_BW = 16;

    localparam int MUL_BW = CNN_I_F_BW + CNN_W_BW;
    localparam int ACC_BW = MUL_BW + clog2(CNN_CI * CNN_KX * CNN_KY);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC  = 2'd1,
        ST_BIAS = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    // Clamp a signed ACC_BW value into the signed O_F_BW range. The value
    // fits when every bit from the output sign bit upward is identical.
    function automatic logic [CNN_O_F_BW-1:0] saturate(input logic [ACC_BW-1:0] v);
        logic [ACC_BW-CNN_O_F_BW:0] top;
        top = v[ACC_BW-1:CNN_O_F_BW-1];
        if (top == '0 || top == '1) return v[CNN_O_F_BW-1:0];
        else if (v[ACC_BW-1])       return {1'b1, {(CNN_O_F_BW-1){1'b0}}};
        else                        return {1'b0, {(CNN_O_F_BW-1){1'b1}}};
    endfunction

endpackage

// File: rtl/cnn_mac_lane.sv
// One output channel: NT-term signed dot product of the current beat plus a
// running accumulator. first_i restarts the sum, clr_i discards it.
module cnn_mac_lane #(
    parameter int NT     = 18,
    parameter int I_F_BW = 8,
    parameter int W_BW   = 8,
    parameter int ACC_BW = 22
) (
    input  logic                   clk,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic                   first_i,
    input  logic [NT*I_F_BW-1:0]   fmap_i,
    input  logic [NT*W_BW-1:0]     wgt_i,
    output logic [ACC_BW-1:0]      acc_o
);
    localparam int MUL_W = I_F_BW + W_BW;

    logic signed [MUL_W-1:0] prod [NT];
    logic [ACC_BW-1:0]       dot;
    logic [ACC_BW-1:0]       acc_q, acc_d;

    for (genvar i = 0; i < NT; i++) begin : g_mul
        assign prod[i] = $signed(fmap_i[i*I_F_BW +: I_F_BW]) * $signed(wgt_i[i*W_BW +: W_BW]);
    end

    // Sign-extended sum of all products in this beat.
    always_comb begin
        dot = '0;
        for (int i = 0; i < NT; i++) begin
            dot = dot + {{(ACC_BW-MUL_W){prod[i][MUL_W-1]}}, prod[i]};
        end
    end

    // Accumulate on a handshake; first beat starts from zero.
    always_comb begin
        acc_d = acc_q;
        if (en_i) acc_d = first_i ? dot : acc_q + dot;
    end

    // Accumulator register; clear wins over any handshake.
    always_ff @(posedge clk) begin
        if (clr_i) acc_q <= '0;
        else       acc_q <= acc_d;
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/cnn_core_seq.sv
// Time-multiplexed CNN core: accumulates CI/CI_PAR beats per window on CO
// lanes, adds bias, saturates and holds the result on a valid/ready port.
// Define CNN_CORE_RELU_EN to zero negative lanes after saturation.
module cnn_core_seq
    import cnn_core_pkg::*;
#(
    parameter int CO     = 4,
    parameter int CI     = 4,
    parameter int CI_PAR = 2,
    parameter int KX     = 3,
    parameter int KY     = 3,
    parameter int I_F_BW = 8,
    parameter int W_BW   = 8,
    parameter int B_BW   = 16,
    parameter int O_F_BW = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            i_soft_reset,
    input  logic                            i_in_valid,
    output logic                            o_in_ready,
    input  logic [CI_PAR*KX*KY*I_F_BW-1:0]  i_in_fmap,
    input  logic [CO*CI_PAR*KX*KY*W_BW-1:0] i_cnn_weight,
    input  logic [CO*B_BW-1:0]              i_cnn_bias,
    output logic                            o_ot_valid,
    input  logic                            i_ot_ready,
    output logic [CO*O_F_BW-1:0]            o_ot_fmap,
    output logic                            o_busy
);
    localparam int NT      = CI_PAR * KX * KY;
    localparam int NBEAT   = CI / CI_PAR;
    localparam int BEAT_BW = (NBEAT > 1) ? clog2(NBEAT) : 1;

    if (CI % CI_PAR != 0) begin : g_bad_ci
        $error("CI must be a multiple of CI_PAR");
    end
    if (I_F_BW + W_BW + clog2(CI*KX*KY) != ACC_BW || O_F_BW != CNN_O_F_BW || B_BW > ACC_BW) begin : g_bad_w
        $error("widths do not match the cnn_core_pkg arithmetic widths");
    end

    state_e               state_q, state_d;
    logic [BEAT_BW-1:0]   beat_q, beat_d;
    logic [CO*O_F_BW-1:0] ot_fmap_q, ot_fmap_d;
    logic [CO*O_F_BW-1:0] res;
    logic [CO*ACC_BW-1:0] acc;
    logic                 clr, hs, last;

    assign clr        = reset | i_soft_reset;
    assign o_in_ready = (state_q == ST_IDLE) || (state_q == ST_ACC);
    assign hs         = i_in_valid && o_in_ready;
    assign last       = (beat_q == BEAT_BW'(NBEAT - 1));
    assign o_busy     = (state_q != ST_IDLE);
    assign o_ot_valid = (state_q == ST_OUT);
    assign o_ot_fmap  = ot_fmap_q;

    for (genvar c = 0; c < CO; c++) begin : g_lane
        logic [ACC_BW-1:0] sum;
        logic [O_F_BW-1:0] sat;

        cnn_mac_lane #(
            .NT     (NT),
            .I_F_BW (I_F_BW),
            .W_BW   (W_BW),
            .ACC_BW (ACC_BW)
        ) u_lane (
            .clk     (clk),
            .clr_i   (clr),
            .en_i    (hs),
            .first_i (beat_q == '0),
            .fmap_i  (i_in_fmap),
            .wgt_i   (i_cnn_weight[c*NT*W_BW +: NT*W_BW]),
            .acc_o   (acc[c*ACC_BW +: ACC_BW])
        );

        // Bias add, clamp to output range, optional rectification.
        always_comb begin
            sum = acc[c*ACC_BW +: ACC_BW]
                + {{(ACC_BW-B_BW){i_cnn_bias[c*B_BW+B_BW-1]}}, i_cnn_bias[c*B_BW +: B_BW]};
            sat = saturate(sum);
`ifdef CNN_CORE_RELU_EN
            if (sat[O_F_BW-1]) sat = '0;
`endif
        end

        assign res[c*O_F_BW +: O_F_BW] = sat;
    end

    // Next state, beat count and result capture.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        ot_fmap_d = ot_fmap_q;
        if (hs) beat_d = last ? '0 : beat_q + 1'b1;
        case (state_q)
            ST_IDLE: if (hs) state_d = last ? ST_BIAS : ST_ACC;
            ST_ACC:  if (hs && last) state_d = ST_BIAS;
            ST_BIAS: begin
                state_d   = ST_OUT;
                ot_fmap_d = res;
            end
            ST_OUT:  if (i_ot_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and output registers; either reset discards the window.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= ST_IDLE;
            beat_q    <= '0;
            ot_fmap_q <= '0;
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            ot_fmap_q <= ot_fmap_d;
        end
    end

endmodule

// File: tb/tb_cnn_core_seq.sv
// Self-checking bench for cnn_core_seq: table vectors, hand sequences for
// latency/backpressure/abort/bubbles, and randomized windows vs. a model.
module tb_cnn_core_seq;
    localparam int CO = 4, CI = 4, CI_PAR = 2, KX = 3, KY = 3;
    localparam int I_F_BW = 8, W_BW = 8, B_BW = 16, O_F_BW = 16;
    localparam int NT = CI_PAR*KX*KY, NBEAT = CI/CI_PAR;
    localparam int FM_W = NT*I_F_BW, WT_W = CO*NT*W_BW;

    logic                 clk = 1'b0;
    logic                 reset, i_soft_reset, i_in_valid, i_ot_ready;
    logic                 o_in_ready, o_ot_valid, o_busy;
    logic [FM_W-1:0]      i_in_fmap;
    logic [WT_W-1:0]      i_cnn_weight;
    logic [CO*B_BW-1:0]   i_cnn_bias;
    logic [CO*O_F_BW-1:0] o_ot_fmap;

    cnn_core_seq #(
        .CO(CO), .CI(CI), .CI_PAR(CI_PAR), .KX(KX), .KY(KY),
        .I_F_BW(I_F_BW), .W_BW(W_BW), .B_BW(B_BW), .O_F_BW(O_F_BW)
    ) dut (
        .clk(clk), .reset(reset), .i_soft_reset(i_soft_reset),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_in_fmap(i_in_fmap), .i_cnn_weight(i_cnn_weight), .i_cnn_bias(i_cnn_bias),
        .o_ot_valid(o_ot_valid), .i_ot_ready(i_ot_ready),
        .o_ot_fmap(o_ot_fmap), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0;
    int fm_v [NBEAT][NT];
    int wt_v [NBEAT][CO][NT];
    int bias_v [CO];
    int got [CO];
    int expv [CO];
    logic [FM_W-1:0] fm_pk [NBEAT];
    logic [WT_W-1:0] wt_pk [NBEAT];

    typedef struct {
        int f;
        int w;
        int b;
        int e;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string nm, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    // Reference: plain integer dot product over the whole window.
    function automatic int model_lane(input int c);
        longint s;
        s = bias_v[c];
        for (int b = 0; b < NBEAT; b++)
            for (int t = 0; t < NT; t++)
                s += longint'(fm_v[b][t]) * longint'(wt_v[b][c][t]);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
`ifdef CNN_CORE_RELU_EN
        if (s < 0) s = 0;
`endif
        return int'(s);
    endfunction

    task automatic pack();
        for (int b = 0; b < NBEAT; b++) begin
            for (int t = 0; t < NT; t++) begin
                fm_pk[b][t*I_F_BW +: I_F_BW] = I_F_BW'(fm_v[b][t]);
                for (int c = 0; c < CO; c++)
                    wt_pk[b][(c*NT+t)*W_BW +: W_BW] = W_BW'(wt_v[b][c][t]);
            end
        end
        for (int c = 0; c < CO; c++) i_cnn_bias[c*B_BW +: B_BW] = B_BW'(bias_v[c]);
    endtask

    task automatic fill_uniform(input int f, input int w, input int bs, input bit lane_scaled);
        for (int b = 0; b < NBEAT; b++)
            for (int t = 0; t < NT; t++) begin
                fm_v[b][t] = f;
                for (int c = 0; c < CO; c++) wt_v[b][c][t] = lane_scaled ? w*(c+1) : w;
            end
        for (int c = 0; c < CO; c++) bias_v[c] = bs;
        pack();
    endtask

    task automatic send_beat(input int b);
        int n;
        n = 0;
        @(negedge clk);
        i_in_valid   = 1'b1;
        i_in_fmap    = fm_pk[b];
        i_cnn_weight = wt_pk[b];
        while (!o_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!o_in_ready) begin
            nerr++;
            $display("FAIL in_ready_timeout: got 0, want 1");
            $display("Result: errors=%0d of %0d checks", nerr, nchk);
            $fatal(1, "stalled input");
        end
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        chk("busy_after_beat", o_busy, 1);
    endtask

    // Drive one window, wait for the result, optionally stall the output.
    task automatic run_txn(input int gap, input int hold);
        int lat;
        logic [CO*O_F_BW-1:0] snap;
        logic signed [O_F_BW-1:0] lv;
        i_ot_ready = (hold == 0);
        for (int b = 0; b < NBEAT; b++) begin
            send_beat(b);
            if (b < NBEAT-1) repeat (gap) @(posedge clk);
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!o_ot_valid) chk("busy_in_bias", o_busy, 1);
        end while (!o_ot_valid && lat < 20);
        chk("latency", lat, 2);
        chk("busy_in_out", o_busy, 1);
        snap = o_ot_fmap;
        for (int c = 0; c < CO; c++) begin
            lv = o_ot_fmap[c*O_F_BW +: O_F_BW];
            got[c] = int'(lv);
        end
        repeat (hold) begin
            @(negedge clk);
            chk("bp_valid_held", o_ot_valid, 1);
            chk("bp_fmap_stable", (o_ot_fmap == snap), 1);
            chk("bp_in_ready_low", o_in_ready, 0);
        end
        i_ot_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_accept", o_busy, 0);
        chk("ready_after_accept", o_in_ready, 1);
    endtask

    task automatic check_lanes(input string nm);
        for (int c = 0; c < CO; c++) chk(nm, got[c], expv[c]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{f: 1,   w: 1,    b: 0,   e: 36};
        tbl[2] = '{f: 127, w: 127,  b: 0,   e: 32767};
`ifdef CNN_CORE_RELU_EN
        tbl[1] = '{f: 1,   w: 1,    b: -50, e: 0};
        tbl[3] = '{f: 127, w: -128, b: 0,   e: 0};
`else
        tbl[1] = '{f: 1,   w: 1,    b: -50, e: -14};
        tbl[3] = '{f: 127, w: -128, b: 0,   e: -32768};
`endif
        reset = 1'b1; i_soft_reset = 1'b0; i_in_valid = 1'b0; i_ot_ready = 1'b1;
        i_in_fmap = '0; i_cnn_weight = '0; i_cnn_bias = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", o_ot_valid, 0);
        chk("rst_fmap", o_ot_fmap, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_in_ready", o_in_ready, 1);
        reset = 1'b0;

        // Uniform-value windows: unit, negative, both saturation rails.
        for (int k = 0; k < 4; k++) begin
            fill_uniform(tbl[k].f, tbl[k].w, tbl[k].b, 1'b0);
            run_txn(0, 0);
            for (int c = 0; c < CO; c++) expv[c] = tbl[k].e;
            check_lanes($sformatf("table%0d", k));
        end

        // Backpressure for 5 cycles, then the next window goes straight in.
        fill_uniform(1, 1, 0, 1'b0);
        run_txn(0, 5);
        for (int c = 0; c < CO; c++) expv[c] = 36;
        check_lanes("bp_result");
        run_txn(0, 0);
        check_lanes("post_bp_result");

        // Abort after beat 0 of a 99-valued window.
        fill_uniform(99, 99, 0, 1'b0);
        send_beat(0);
        @(negedge clk);
        i_soft_reset = 1'b1;
        @(posedge clk);
        #1;
        i_soft_reset = 1'b0;
        chk("abort_valid", o_ot_valid, 0);
        chk("abort_fmap", o_ot_fmap, 0);
        chk("abort_busy", o_busy, 0);
        chk("abort_in_ready", o_in_ready, 1);
        // Soft reset coinciding with a handshake: the reset wins.
        @(negedge clk);
        i_in_valid = 1'b1;
        i_soft_reset = 1'b1;
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        i_soft_reset = 1'b0;
        chk("soft_vs_hs_busy", o_busy, 0);
        fill_uniform(1, 1, 0, 1'b0);
        run_txn(0, 0);
        for (int c = 0; c < CO; c++) expv[c] = 36;
        check_lanes("post_abort");

        // Bubbles between beats and per-lane weights c+1.
        fill_uniform(1, 1, 0, 1'b1);
        for (int c = 0; c < CO; c++) expv[c] = 36*(c+1);
        run_txn(3, 0);
        check_lanes("bubbles_gap3");
        run_txn(0, 0);
        check_lanes("bubbles_nogap");

        // Randomized windows vs. the integer model.
        for (int k = 0; k < 30; k++) begin
            for (int b = 0; b < NBEAT; b++)
                for (int t = 0; t < NT; t++) begin
                    fm_v[b][t] = (k % 3 == 0) ? 127 - int'($urandom_range(3))
                                              : int'($urandom_range(255)) - 128;
                    for (int c = 0; c < CO; c++)
                        wt_v[b][c][t] = (k % 3 == 0) ? ((c % 2 == 0) ? 127 : -128)
                                                     : int'($urandom_range(255)) - 128;
                end
            for (int c = 0; c < CO; c++) bias_v[c] = int'($urandom_range(65535)) - 32768;
            pack();
            for (int c = 0; c < CO; c++) expv[c] = model_lane(c);
            run_txn(int'($urandom_range(2)), int'($urandom_range(3)));
            check_lanes($sformatf("rand%0d", k));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
